// File: rtl/snake_engine_if.sv
// Control and status bundle between the snake engine and its controller/display stage.
// Blocks is numbered ascending so that bit 0 is the MSB of cell (0,0).
interface snake_engine_if #(
    parameter int GRID_WIDTH  = 16,
    parameter int GRID_HEIGHT = 12
);
    logic                                Tick;
    logic [1:0]                          Direction;
    logic                                Restart;
    logic [0:2*GRID_HEIGHT*GRID_WIDTH-1] Blocks;
    logic [5:0]                          Length;
    logic                                GameOver;
    logic                                Busy;

    modport master (
        output Tick, Direction, Restart,
        input  Blocks, Length, GameOver, Busy
    );

    modport slave (
        input  Tick, Direction, Restart,
        output Blocks, Length, GameOver, Busy
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game engine: registered play-field grid, circular body buffer and LFSR food placement.
// Cell codes: 00 empty, 01 snake, 10 food, 11 wall.
module snake_engine #(
    parameter int GRID_WIDTH  = 16,
    parameter int GRID_HEIGHT = 12,
    parameter int MAX_LEN     = 32
) (
    input logic          Clock,
    input logic          ResetN,
    snake_engine_if.slave bus
);
    localparam int CELLS = GRID_WIDTH * GRID_HEIGHT;
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {INIT, IDLE, STEP, PLACE_FOOD, DEAD} state_t;
    typedef enum logic [1:0] {UP = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, LEFT = 2'b11} heading_t;
    typedef enum logic [1:0] {
        BLOCK_EMPTY = 2'b00, BLOCK_SNAKE = 2'b01, BLOCK_FOOD = 2'b10, BLOCK_WALL = 2'b11
    } block_t;

    state_t             state;
    heading_t           heading;
    logic [0:2*CELLS-1] grid;
    logic [7:0]         body [MAX_LEN];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [7:0]         lfsr;
    logic [3:0]         next_x;
    logic [3:0]         next_y;
    logic [5:0]         length;
    logic               game_over;
    logic               busy;

    function automatic block_t initial_cell(input int unsigned x, input int unsigned y);
        if (x == 0 || x == GRID_WIDTH - 1 || y == 0 || y == GRID_HEIGHT - 1)
            return BLOCK_WALL;
        if (y == 6 && x >= 4 && x <= 6)
            return BLOCK_SNAKE;
        if (y == 6 && x == 10)
            return BLOCK_FOOD;
        return BLOCK_EMPTY;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == MAX_LEN - 1) ? '0 : p + PTR_W'(1);
    endfunction

    heading_t     new_heading;
    logic [7:0]   head_cell;
    logic [3:0]   cand_x;
    logic [3:0]   cand_y;

    always_comb begin
        head_cell   = body[head_ptr];
        new_heading = heading;
        if (bus.Direction != (heading ^ 2'b10))
            new_heading = heading_t'(bus.Direction);
        cand_x = head_cell[7:4];
        cand_y = head_cell[3:0];
        case (new_heading)
            UP:      cand_y = head_cell[3:0] - 4'd1;
            RIGHT:   cand_x = head_cell[7:4] + 4'd1;
            DOWN:    cand_y = head_cell[3:0] + 4'd1;
            default: cand_x = head_cell[7:4] - 4'd1;
        endcase
    end

    int unsigned  next_base;
    int unsigned  tail_base;
    int unsigned  food_base;
    block_t       next_code;
    logic [7:0]   tail_cell;
    logic         hits_tail;
    logic         step_dies;
    logic         ate_food;
    logic [3:0]   food_x;
    logic [3:0]   food_y;
    logic         food_in_range;
    logic         food_ok;

    always_comb begin
        next_base = 2 * (32'(next_y) * GRID_WIDTH + 32'(next_x));
        next_code = block_t'(grid[next_base +: 2]);
        tail_cell = body[tail_ptr];
        tail_base = 2 * (32'(tail_cell[3:0]) * GRID_WIDTH + 32'(tail_cell[7:4]));
        hits_tail = (tail_cell == {next_x, next_y});
        // Entering the tail cell is legal because the tail vacates it on the same step.
        step_dies = (next_code == BLOCK_WALL) || (next_code == BLOCK_SNAKE && !hits_tail);
        ate_food  = (next_code == BLOCK_FOOD);

        food_x        = lfsr[3:0];
        food_y        = lfsr[7:4];
        food_in_range = (food_x >= 4'd1) && (32'(food_x) <= GRID_WIDTH - 2) &&
                        (food_y >= 4'd1) && (32'(food_y) <= GRID_HEIGHT - 2);
        food_base     = food_in_range ? 2 * (32'(food_y) * GRID_WIDTH + 32'(food_x)) : 0;
        food_ok       = food_in_range && (block_t'(grid[food_base +: 2]) == BLOCK_EMPTY);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= INIT;
            busy      <= 1'b1;
            lfsr      <= 8'hA5;
            game_over <= 1'b0;
            length    <= 6'd3;
            heading   <= RIGHT;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            next_x    <= '0;
            next_y    <= '0;
            for (int unsigned i = 0; i < CELLS; i++)
                grid[2*i +: 2] <= initial_cell(i % GRID_WIDTH, i / GRID_WIDTH);
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (bus.Restart) begin
                state     <= INIT;
                busy      <= 1'b1;
                game_over <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        for (int unsigned i = 0; i < CELLS; i++)
                            grid[2*i +: 2] <= initial_cell(i % GRID_WIDTH, i / GRID_WIDTH);
                        length   <= 6'd3;
                        heading  <= RIGHT;
                        head_ptr <= PTR_W'(2);
                        tail_ptr <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                    IDLE: begin
                        if (bus.Tick && !game_over) begin
                            heading <= new_heading;
                            next_x  <= cand_x;
                            next_y  <= cand_y;
                            state   <= STEP;
                            busy    <= 1'b1;
                        end
                    end
                    STEP: begin
                        if (step_dies) begin
                            game_over <= 1'b1;
                            state     <= DEAD;
                            busy      <= 1'b0;
                        end else if (ate_food && 32'(length) < MAX_LEN) begin
                            grid[next_base +: 2] <= BLOCK_SNAKE;
                            head_ptr <= ptr_inc(head_ptr);
                            length   <= length + 6'd1;
                            state    <= PLACE_FOOD;
                        end else begin
                            // Later write wins, so a head landing on the old tail stays SNAKE.
                            grid[tail_base +: 2] <= BLOCK_EMPTY;
                            grid[next_base +: 2] <= BLOCK_SNAKE;
                            head_ptr <= ptr_inc(head_ptr);
                            tail_ptr <= ptr_inc(tail_ptr);
                            state    <= ate_food ? PLACE_FOOD : IDLE;
                            busy     <= ate_food;
                        end
                    end
                    PLACE_FOOD: begin
                        if (food_ok) begin
                            grid[food_base +: 2] <= BLOCK_FOOD;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    DEAD: begin
                        busy <= 1'b0;
                    end
                    default: begin
                        state <= INIT;
                        busy  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Body store carries no reset: INIT always rewrites the live entries before use.
    always_ff @(posedge Clock) begin
        if (state == INIT) begin
            body[0] <= {4'd4, 4'd6};
            body[1] <= {4'd5, 4'd6};
            body[2] <= {4'd6, 4'd6};
        end else if (state == STEP && !step_dies && !bus.Restart && ResetN) begin
            body[ptr_inc(head_ptr)] <= {next_x, next_y};
        end
    end

    assign bus.Blocks   = grid;
    assign bus.Length   = length;
    assign bus.GameOver = game_over;
    assign bus.Busy     = busy;
endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed scenarios plus random steering against a queue-based game model.
module tb_snake_engine;
    localparam int W     = 16;
    localparam int H     = 12;
    localparam int ML    = 32;
    localparam int CELLS = W * H;
    localparam logic [1:0] C_EMPTY = 2'b00;
    localparam logic [1:0] C_SNAKE = 2'b01;
    localparam logic [1:0] C_FOOD  = 2'b10;
    localparam logic [1:0] C_WALL  = 2'b11;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;

    snake_engine_if #(.GRID_WIDTH(W), .GRID_HEIGHT(H)) bus ();

    snake_engine #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .MAX_LEN(ML)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: snake as coordinate queues (index 0 = tail, last = head).
    int   sx[$];
    int   sy[$];
    int   food_x, food_y;
    bit   has_food;
    bit   m_dead;
    int   m_head;
    logic [7:0] m_lfsr;

    // Polynomial x^8+x^6+x^5+x^4+1: feedback is the parity of bits 7,5,4,3.
    always @(posedge Clock or negedge ResetN)
        if (!ResetN) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};

    function automatic void model_reinit();
        sx = '{4, 5, 6};
        sy = '{6, 6, 6};
        food_x = 10; food_y = 6; has_food = 1'b1;
        m_dead = 1'b0;
        m_head = 1;
    endfunction

    function automatic bit model_occupied(input int x, input int y);
        for (int i = 0; i < sx.size(); i++)
            if (sx[i] == x && sy[i] == y) return 1'b1;
        return has_food && food_x == x && food_y == y;
    endfunction

    function automatic logic [0:2*CELLS-1] model_grid();
        logic [0:2*CELLS-1] g;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                g[2*(y*W+x) +: 2] = (x == 0 || x == W-1 || y == 0 || y == H-1) ? C_WALL : C_EMPTY;
        for (int i = 0; i < sx.size(); i++)
            g[2*(sy[i]*W+sx[i]) +: 2] = C_SNAKE;
        if (has_food)
            g[2*(food_y*W+food_x) +: 2] = C_FOOD;
        return g;
    endfunction

    function automatic logic [1:0] dut_cell(input int x, input int y);
        return bus.Blocks[2*(y*W+x) +: 2];
    endfunction

    function automatic int dut_food_count();
        int n = 0;
        for (int i = 0; i < CELLS; i++)
            if (bus.Blocks[2*i +: 2] == C_FOOD) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_grid(input string tag);
        logic [0:2*CELLS-1] e;
        e = model_grid();
        n_checks++;
        assert (bus.Blocks === e) else begin
            n_fail++;
            $error("FAIL %s: grid observed %h expected %h", tag, bus.Blocks, e);
        end
    endtask

    task automatic check_state(input string tag);
        chk_grid({tag, "_grid"});
        chk({tag, "_len"}, bus.Length, sx.size());
        chk({tag, "_gameover"}, bus.GameOver, m_dead);
        chk({tag, "_busy"}, bus.Busy, 0);
    endtask

    task automatic model_step(input logic [1:0] dir, output bit eat);
        int nx, ny;
        bit hit;
        eat = 1'b0;
        if (int'(dir) != (m_head ^ 2)) m_head = dir;
        nx = sx[$];
        ny = sy[$];
        case (m_head)
            0: ny--;
            1: nx++;
            2: ny++;
            default: nx--;
        endcase
        hit = (nx == 0 || nx == W-1 || ny == 0 || ny == H-1);
        for (int i = 1; i < sx.size(); i++)
            if (sx[i] == nx && sy[i] == ny) hit = 1'b1;
        if (hit) begin
            m_dead = 1'b1;
            return;
        end
        if (has_food && nx == food_x && ny == food_y) begin
            eat = 1'b1;
            has_food = 1'b0;
        end
        if (!(eat && sx.size() < ML)) begin
            void'(sx.pop_front());
            void'(sy.pop_front());
        end
        sx.push_back(nx);
        sy.push_back(ny);
    endtask

    // Food goes to the first in-range empty cell named by the LFSR value present before an edge.
    task automatic place_food();
        bit placed = 1'b0;
        for (int n = 0; n < 1000 && !placed; n++) begin
            int cx, cy;
            cx = int'(m_lfsr[3:0]);
            cy = int'(m_lfsr[7:4]);
            chk("busy_place", bus.Busy, 1);
            if (cx >= 1 && cx <= W-2 && cy >= 1 && cy <= H-2 && !model_occupied(cx, cy)) begin
                food_x = cx; food_y = cy; has_food = 1'b1;
                placed = 1'b1;
            end
            @(posedge Clock); #1;
        end
        n_checks++;
        assert (placed) else begin
            n_fail++;
            $error("FAIL food_timeout: observed %0d expected %0d", placed, 1);
        end
    endtask

    task automatic do_tick(input logic [1:0] dir, input int width);
        bit eat;
        bus.Direction = dir;
        bus.Tick      = 1'b1;
        if (m_dead) begin
            @(posedge Clock); #1 bus.Tick = 1'b0;
            @(posedge Clock); #1;
            check_state("dead_tick");
            return;
        end
        @(posedge Clock); #1;
        if (width < 2) bus.Tick = 1'b0;
        chk("busy_step", bus.Busy, 1);
        @(posedge Clock); #1 bus.Tick = 1'b0;
        model_step(dir, eat);
        if (eat) place_food();
        check_state("tick");
    endtask

    task automatic do_restart();
        bus.Restart = 1'b1;
        @(posedge Clock); #1 bus.Restart = 1'b0;
        chk("restart_busy", bus.Busy, 1);
        chk("restart_go_clear", bus.GameOver, 0);
        @(posedge Clock); #1;
        model_reinit();
        check_state("restart");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Tick      = 1'b0;
        bus.Direction = 2'b01;
        bus.Restart   = 1'b0;
        ResetN        = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        model_reinit();
        chk_grid("reset_grid");
        chk("reset_len", bus.Length, 3);
        chk("reset_gameover", bus.GameOver, 0);
        chk("reset_busy", bus.Busy, 1);
        ResetN = 1'b1;
        @(posedge Clock); #1;
        check_state("init_done");

        // Four steps right: the fourth eats the food at (10,6).
        for (int i = 0; i < 4; i++) do_tick(2'b01, 1);
        chk("eat_len", bus.Length, 4);
        chk("eat_food_count", dut_food_count(), 1);
        chk("eat_head", dut_cell(10, 6), C_SNAKE);

        // Reversal request is ignored.
        do_restart();
        do_tick(2'b11, 1);
        chk("reverse_head", dut_cell(7, 6), C_SNAKE);
        chk("reverse_tail", dut_cell(4, 6), C_EMPTY);

        // Steer up into the top wall; further ticks are ignored.
        do_restart();
        for (int i = 0; i < 6; i++) do_tick(2'b00, 1);
        chk("wall_gameover", bus.GameOver, 1);
        do_tick(2'b01, 1);
        do_tick(2'b10, 2);

        // Restart from the dead state.
        do_restart();

        // Length-4 square loop: head enters the cell the tail leaves.
        for (int i = 0; i < 4; i++) do_tick(2'b01, 1);
        do_tick(2'b00, 1);
        do_tick(2'b11, 1);
        do_tick(2'b10, 1);
        chk("loop_gameover", bus.GameOver, 0);
        chk("loop_head", dut_cell(9, 6), C_SNAKE);

        // Random steering with idle gaps and occasional long Tick pulses.
        do_restart();
        for (int k = 0; k < 80; k++) begin
            if (m_dead) begin
                do_tick(2'($urandom_range(0, 3)), 1);
                do_restart();
            end else begin
                do_tick(2'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge Clock); #1;
            end
        end

        // Reset asserted while food placement is pending.
        do_restart();
        for (int i = 0; i < 3; i++) do_tick(2'b01, 1);
        bus.Direction = 2'b01;
        bus.Tick = 1'b1;
        @(posedge Clock); #1 bus.Tick = 1'b0;
        @(posedge Clock); #1;
        chk("pf_busy", bus.Busy, 1);
        ResetN = 1'b0;
        #1;
        model_reinit();
        chk_grid("pf_reset_grid");
        chk("pf_reset_len", bus.Length, 3);
        chk("pf_reset_gameover", bus.GameOver, 0);
        chk("pf_reset_food_count", dut_food_count(), 1);
        @(negedge Clock);
        ResetN = 1'b1;
        @(posedge Clock); #1;
        check_state("pf_post_reset");
        do_tick(2'b01, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
